// File: rtl/spi_resp_pkg.sv
// Shared command-byte layout, FSM states and sizing defaults for the SPI responder.
package spi_resp_pkg;
  localparam int CMD_ADDR_MSB = 7;
  localparam int CMD_ADDR_LSB = 3;
  localparam int CMD_WR_BIT   = 1;
  localparam int DEF_ADDR_W   = 5;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;
endpackage

// File: rtl/spi_in_sync.sv
// N-stage synchronizer for one SPI pin, plus one extra stage for rise/fall detect.
module spi_in_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 target exposing a byte register file, oversampled in the system clock domain.
module spi_responder
  import spi_resp_pkg::*;
#(
  parameter int NUM_REGS    = 2 ** DEF_ADDR_W,
  parameter int SYNC_STAGES = 2,
  localparam int ADDR_W     = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_ss_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [7:0]        status_in,
  input  logic [ADDR_W-1:0] fab_addr,
  input  logic              fab_we,
  input  logic [7:0]        fab_wdata,
  output logic [7:0]        fab_rdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              xfer_done
);
  logic sclk_rise_raw, sclk_fall_raw, ss_q, ss_fall, ss_rise, mosi_q;

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .reset(reset), .d(spi_sclk), .q(), .rise(sclk_rise_raw), .fall(sclk_fall_raw));
  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk(clk), .reset(reset), .d(spi_ss_n), .q(ss_q), .rise(ss_rise), .fall(ss_fall));
  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .reset(reset), .d(spi_mosi), .q(mosi_q), .rise(), .fall());

  state_e            state, state_nx;
  logic [SYNC_STAGES:0] settle;
  logic              armed;
  logic [2:0]        bit_cnt;
  logic [6:0]        rx_sh;
  logic [7:0]        tx_sh, pend;
  logic [ADDR_W-1:0] addr, addr_inc, cmd_addr;
  logic              is_wr, load_pend;
  logic [7:0]        regs [NUM_REGS];

  logic       active, rise, fall, byte_end, spi_we, start;
  logic [7:0] rx_byte;
  logic [4:0] cmd_field;

  assign active    = (state != IDLE);
  assign rise      = sclk_rise_raw & ~ss_q & active;
  assign fall      = sclk_fall_raw & ~ss_q & active;
  assign rx_byte   = {rx_sh, mosi_q};
  assign byte_end  = rise & (bit_cnt == 3'd7);
  assign spi_we    = (state == DATA) & byte_end & is_wr;
  assign start     = (state == IDLE) & ss_fall & armed;
  assign cmd_field = rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
  assign cmd_addr  = cmd_field[ADDR_W-1:0];
  assign addr_inc  = addr + ADDR_W'(1);

  assign spi_miso    = active & tx_sh[7];
  assign spi_miso_oe = active;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CMD;
      CMD:     if (byte_end) state_nx = DATA;
      default: ;
    endcase
    if (ss_rise) state_nx = IDLE;
  end

  // A select already low when reset releases must be ignored: only arm once ss_n is seen high
  // after the synchronizer has flushed its reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      settle    <= '0;
      armed     <= 1'b0;
      bit_cnt   <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      pend      <= '0;
      addr      <= '0;
      is_wr     <= 1'b0;
      load_pend <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      xfer_done <= 1'b0;
      fab_rdata <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      settle    <= {settle[SYNC_STAGES-1:0], 1'b1};
      if (settle[SYNC_STAGES] && ss_q) armed <= 1'b1;
      wr_strobe <= spi_we;
      xfer_done <= ss_rise && (state == DATA);
      fab_rdata <= regs[fab_addr];

      if (start) begin
        tx_sh     <= status_in;
        bit_cnt   <= '0;
        load_pend <= 1'b0;
      end
      if (fall) begin
        if (load_pend) begin
          tx_sh     <= pend;
          load_pend <= 1'b0;
        end else begin
          tx_sh <= {tx_sh[6:0], 1'b0};
        end
      end
      if (rise) begin
        rx_sh   <= rx_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
      end
      // Read data is captured on the 8th rise, before any same-cycle fabric write lands.
      if (byte_end) begin
        load_pend <= 1'b1;
        if (state == CMD) begin
          addr  <= cmd_addr;
          is_wr <= rx_byte[CMD_WR_BIT];
          pend  <= rx_byte[CMD_WR_BIT] ? 8'h00 : regs[cmd_addr];
        end else begin
          addr <= addr_inc;
          pend <= is_wr ? 8'h00 : regs[addr_inc];
        end
      end

      // SPI write is ordered last so it wins a same-address collision.
      if (fab_we) regs[fab_addr] <= fab_wdata;
      if (spi_we) begin
        regs[addr] <= rx_byte;
        wr_addr    <= addr;
        wr_data    <= rx_byte;
      end
    end
  end
endmodule
